// File: rtl/clk_switch_pkg.sv
// Shared types and defaults for the clock-switch controller.
package clk_switch_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StCheck  = 3'd1,
    StSwitch = 3'd2,
    StSettle = 3'd3,
    StAck    = 3'd4,
    StErr    = 3'd5
  } sw_state_e;

  localparam int unsigned SettleCycDefault = 8;
  localparam int unsigned AliveWinDefault  = 16;
  localparam int unsigned AliveMinDefault  = 2;

  // All timers/edge counters fit parameters up to 255.
  localparam int unsigned CntW = 8;

  // Increment v by one when en is set, never exceeding lim.
  function automatic logic [CntW-1:0] sat_inc(logic [CntW-1:0] v, logic en,
                                              logic [CntW-1:0] lim);
    return (en && (v < lim)) ? v + CntW'(1) : v;
  endfunction

endpackage

// File: rtl/clk_switch_ctrl_if.sv
// Request/status bundle between a requester and the clock-switch controller.
interface clk_switch_ctrl_if;
  logic sw_req;
  logic sw_tgt;
  logic selb;
  logic cur_selb;
  logic busy;
  logic sw_ack;
  logic sw_err;
  logic wdog_evt;

  modport master (
    output sw_req, sw_tgt,
    input  selb, cur_selb, busy, sw_ack, sw_err, wdog_evt
  );

  modport slave (
    input  sw_req, sw_tgt,
    output selb, cur_selb, busy, sw_ack, sw_err, wdog_evt
  );
endinterface

// File: rtl/clk_sw_sync_edge.sv
// Brings the clkb-domain toggle into clka_n and flags each change as a one-cycle pulse.
module clk_sw_sync_edge (
  input  logic clka_n,
  input  logic rst_n,
  input  logic tgl_i,
  output logic edge_o
);

  // [0],[1] form the synchronizer; [2] holds the previous synchronized value.
  logic [2:0] sync_q;

  // Shift the toggle through the three flops.
  always_ff @(posedge clka_n or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], tgl_i};
    end
  end

  assign edge_o = sync_q[1] ^ sync_q[2];

endmodule

// File: rtl/clk_switch_ctrl.sv
// Sequences selb changes for a glitch-free clka/clkb switch, checking clkb is alive before
// moving onto it. Define CLK_SW_WDOG_EN to also watch clkb while it is the committed source
// and fall back to clka when it dies.
module clk_switch_ctrl
  import clk_switch_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = SettleCycDefault,
  parameter int unsigned ALIVE_WIN  = AliveWinDefault,
  parameter int unsigned ALIVE_MIN  = AliveMinDefault
) (
  input  logic             clka_n,
  input  logic             rst_n,
  input  logic             clkb_tgl,
  clk_switch_ctrl_if.slave sw_if
);

  localparam logic [CntW-1:0] WinLast    = CntW'(ALIVE_WIN - 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYC - 1);
  localparam logic [CntW-1:0] AliveMin   = CntW'(ALIVE_MIN);

  sw_state_e       state_q, state_d;
  logic [CntW-1:0] tmr_q, tmr_d;
  logic [CntW-1:0] ecnt_q, ecnt_d;
  logic            tgt_q, tgt_d;
  logic            selb_q, selb_d;
  logic            cur_q, cur_d;
  logic            wdog_q, wdog_d;

  logic            edge_pls;
  logic [CntW-1:0] ecnt_step;
  logic            win_end;
  logic            alive;
  logic            wdog_trip;

  clk_sw_sync_edge u_sync (
    .clka_n (clka_n),
    .rst_n  (rst_n),
    .tgl_i  (clkb_tgl),
    .edge_o (edge_pls)
  );

  // Next-state logic; timer and edge count clear on every state change by default.
  always_comb begin
    state_d   = state_q;
    tmr_d     = '0;
    ecnt_d    = '0;
    tgt_d     = tgt_q;
    selb_d    = selb_q;
    cur_d     = cur_q;
    wdog_d    = wdog_q;
    wdog_trip = 1'b0;
    ecnt_step = sat_inc(ecnt_q, edge_pls, AliveMin);
    win_end   = (tmr_q == WinLast);
    alive     = (ecnt_step >= AliveMin);

    unique case (state_q)
      StIdle: begin
        wdog_d = 1'b0;
`ifdef CLK_SW_WDOG_EN
        // Back-to-back liveness windows while clkb is the committed source.
        if (cur_q) begin
          if (win_end) begin
            wdog_trip = !alive;
          end else begin
            tmr_d  = tmr_q + CntW'(1);
            ecnt_d = ecnt_step;
          end
        end
`endif
        if (wdog_trip) begin
          // Trip wins over a same-edge request, which is dropped.
          tgt_d   = 1'b0;
          selb_d  = 1'b0;
          wdog_d  = 1'b1;
          tmr_d   = '0;
          ecnt_d  = '0;
          state_d = StSwitch;
        end else if (sw_if.sw_req) begin
          tgt_d  = sw_if.sw_tgt;
          tmr_d  = '0;
          ecnt_d = '0;
          if (sw_if.sw_tgt == cur_q) begin
            state_d = StAck;
          end else if (sw_if.sw_tgt) begin
            state_d = StCheck;
          end else begin
            selb_d  = 1'b0;
            state_d = StSwitch;
          end
        end
      end
      StCheck: begin
        if (win_end) begin
          if (alive) begin
            selb_d  = tgt_q;
            state_d = StSwitch;
          end else begin
            state_d = StErr;
          end
        end else begin
          tmr_d  = tmr_q + CntW'(1);
          ecnt_d = ecnt_step;
        end
      end
      StSwitch: state_d = StSettle;
      StSettle: begin
        if (tmr_q == SettleLast) begin
          cur_d   = tgt_q;
          state_d = StAck;
        end else begin
          tmr_d = tmr_q + CntW'(1);
        end
      end
      StAck:   state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any sequence and returns selb to clka.
  always_ff @(posedge clka_n or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      ecnt_q  <= '0;
      tgt_q   <= 1'b0;
      selb_q  <= 1'b0;
      cur_q   <= 1'b0;
      wdog_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ecnt_q  <= ecnt_d;
      tgt_q   <= tgt_d;
      selb_q  <= selb_d;
      cur_q   <= cur_d;
      wdog_q  <= wdog_d;
    end
  end

  assign sw_if.selb     = selb_q;
  assign sw_if.cur_selb = cur_q;
  assign sw_if.busy     = (state_q != StIdle);
  assign sw_if.sw_ack   = (state_q == StAck) && !wdog_q;
  assign sw_if.sw_err   = (state_q == StErr);
`ifdef CLK_SW_WDOG_EN
  assign sw_if.wdog_evt = (state_q == StAck) && wdog_q;
`else
  assign sw_if.wdog_evt = 1'b0;
`endif

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Self-checking bench for clk_switch_ctrl: timeline model plus pinned literal expectations.
module tb_clk_switch_ctrl;

  localparam int S     = 8;
  localparam int W     = 16;
  localparam int AMIN  = 2;
  localparam int Bound = 2 * W + S + 5;
`ifdef CLK_SW_WDOG_EN
  localparam bit WdogEn = 1'b1;
`else
  localparam bit WdogEn = 1'b0;
`endif

  // Signal indices for literal expectations.
  localparam int SigBusy = 0, SigSelb = 1, SigCur = 2, SigAck = 3, SigErr = 4, SigWdog = 5;

  logic clka_n   = 1'b0;
  logic rst_n    = 1'b0;
  logic clkb_tgl = 1'b0;
  logic probe    = 1'b0;

  clk_switch_ctrl_if sw_if ();

  clk_switch_ctrl #(
    .SETTLE_CYC (S),
    .ALIVE_WIN  (W),
    .ALIVE_MIN  (AMIN)
  ) dut (
    .clka_n   (clka_n),
    .rst_n    (rst_n),
    .clkb_tgl (clkb_tgl),
    .sw_if    (sw_if)
  );

  always #5 clka_n = ~clka_n;

  // ---------------------------------------------------------------- model
  typedef enum int {KNone, KSame, KSw0, KCheck, KWdog} kind_e;

  int    cyc = 0;
  bit    tarr [8192];
  kind_e m_kind = KNone;
  int    m_start = 0;
  int    m_win = 0;
  int    m_d;
  bit    m_selb = 1'b0, m_cur = 1'b0, m_alive = 1'b0, m_trip, m_done;

  // Synchronized edges the controller sees at edges a..b (3-flop delay from the toggle).
  function automatic int edges_in(int a, int b);
    int n = 0;
    for (int j = a; j <= b; j++) begin
      if (j >= 3 && tarr[(j - 2) % 8192] != tarr[(j - 3) % 8192]) n++;
    end
    return n;
  endfunction

  always @(posedge clka_n) begin
    cyc = cyc + 1;
    tarr[cyc % 8192] = rst_n ? clkb_tgl : 1'b0;
    if (!rst_n) begin
      m_kind = KNone;
      m_selb = 1'b0;
      m_cur  = 1'b0;
      m_win  = cyc;
    end else if (m_kind == KNone) begin
      m_trip = 1'b0;
      if (WdogEn && m_cur && (cyc - m_win == W)) begin
        if (edges_in(m_win + 1, cyc) < AMIN) m_trip = 1'b1;
        else m_win = cyc;
      end
      if (m_trip) begin
        m_kind = KWdog; m_start = cyc; m_selb = 1'b0;
      end else if (sw_if.sw_req) begin
        m_start = cyc; m_alive = 1'b0;
        if (sw_if.sw_tgt == m_cur) m_kind = KSame;
        else if (sw_if.sw_tgt) m_kind = KCheck;
        else begin m_kind = KSw0; m_selb = 1'b0; end
      end
    end else begin
      m_d = cyc - m_start;
      m_done = 1'b0;
      case (m_kind)
        KSame: m_done = (m_d == 1);
        KSw0, KWdog: begin
          if (m_d == 1 + S) m_cur = 1'b0;
          m_done = (m_d == 2 + S);
        end
        KCheck: begin
          if (m_d == W) begin
            m_alive = edges_in(m_start + 1, cyc) >= AMIN;
            if (m_alive) m_selb = 1'b1;
          end else if (m_alive && m_d == W + 1 + S) begin
            m_cur = 1'b1;
          end
          m_done = m_alive ? (m_d == W + 2 + S) : (m_d == W + 1);
        end
        default: m_done = 1'b1;
      endcase
      if (m_done) begin m_kind = KNone; m_win = cyc; end
    end
  end

  // ---------------------------------------------------------------- literals
  typedef struct {int at; int sig; logic val; string name;} lit_t;
  lit_t lits[$];
  int   pid = 0, pid_next = 1;
  int   n_vec = 0, n_miss = 0;

  function automatic logic sig_val(int idx);
    case (idx)
      SigBusy: return sw_if.busy;
      SigSelb: return sw_if.selb;
      SigCur:  return sw_if.cur_selb;
      SigAck:  return sw_if.sw_ack;
      SigErr:  return sw_if.sw_err;
      default: return sw_if.wdog_evt;
    endcase
  endfunction

  task automatic check_lits(int key);
    foreach (lits[i]) begin
      if (lits[i].at == key) begin
        n_vec++;
        if (sig_val(lits[i].sig) !== lits[i].val) begin
          n_miss++;
          $display("FAIL %s (cyc %0d): got %b want %b", lits[i].name, cyc,
                   sig_val(lits[i].sig), lits[i].val);
        end
      end
    end
  endtask

  // Single compare process: model every negedge, literal pins at their cycle or probe.
  logic [5:0] exp_v, act_v;
  always @(negedge clka_n or posedge probe) begin
    if (probe) begin
      check_lits(-pid);
    end else begin
      m_d = cyc - m_start;
      if (!rst_n) exp_v = '0;
      else exp_v = {m_kind != KNone, m_selb, m_cur,
                    (m_kind == KSame && m_d == 0) || (m_kind == KSw0 && m_d == 1 + S) ||
                    (m_kind == KCheck && m_alive && m_d == W + 1 + S),
                    m_kind == KCheck && !m_alive && m_d == W,
                    m_kind == KWdog && m_d == 1 + S};
      act_v = {sw_if.busy, sw_if.selb, sw_if.cur_selb, sw_if.sw_ack, sw_if.sw_err,
               sw_if.wdog_evt};
      n_vec++;
      if (act_v !== exp_v) begin
        n_miss++;
        $display("FAIL model cyc %0d busy/selb/cur/ack/err/wdog: got %b want %b",
                 cyc, act_v, exp_v);
      end
      check_lits(cyc);
    end
  end

  // ---------------------------------------------------------------- clkb toggle source
  int tgl_per = 0;
  int tgl_cnt = 0;
  initial forever begin
    @(posedge clka_n);
    #1;
    if (tgl_per != 0) begin
      if (tgl_cnt >= tgl_per - 1) begin clkb_tgl = ~clkb_tgl; tgl_cnt = 0; end
      else tgl_cnt++;
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick(int n);
    repeat (n) begin @(posedge clka_n); #1; end
  endtask

  task automatic expect_at(int at, int sig, logic val, string name);
    lits.push_back('{at: at, sig: sig, val: val, name: name});
  endtask

  task automatic probe_expect(int sig, logic val, string name);
    lits.push_back('{at: -pid_next, sig: sig, val: val, name: name});
  endtask

  task automatic fire_probe();
    pid = pid_next;
    pid_next++;
    probe = 1'b1;
    #1;
    probe = 1'b0;
  endtask

  task automatic req(logic t);
    sw_if.sw_req = 1'b1;
    sw_if.sw_tgt = t;
    tick(1);
    sw_if.sw_req = 1'b0;
  endtask

  int c;
  initial begin
    sw_if.sw_req = 1'b0;
    sw_if.sw_tgt = 1'b0;

    // Reset state.
    tick(2);
    #1;
    probe_expect(SigBusy, 1'b0, "rst_busy");
    probe_expect(SigSelb, 1'b0, "rst_selb");
    probe_expect(SigCur,  1'b0, "rst_cur");
    probe_expect(SigAck,  1'b0, "rst_ack");
    probe_expect(SigWdog, 1'b0, "rst_wdog");
    fire_probe();
    tick(1);
    rst_n = 1'b1;
    tick(3);

    // Same-target request right after reset: ack one cycle later, selb untouched.
    c = cyc;
    expect_at(c + 1, SigAck,  1'b1, "same_ack");
    expect_at(c + 1, SigBusy, 1'b1, "same_busy");
    expect_at(c + 1, SigSelb, 1'b0, "same_selb");
    expect_at(c + 2, SigBusy, 1'b0, "same_idle");
    req(1'b0);
    tick(4);

    // Dead clkb: error after the liveness window, selects unchanged.
    c = cyc;
    expect_at(c + 16, SigErr,  1'b0, "dead_err_early");
    expect_at(c + 17, SigErr,  1'b1, "dead_err");
    expect_at(c + 17, SigSelb, 1'b0, "dead_selb");
    expect_at(c + 18, SigCur,  1'b0, "dead_cur");
    req(1'b1);
    tick(22);

    // Live clkb (toggle every 3 cycles): switch onto clkb.
    tgl_per = 3;
    tick(6);
    c = cyc;
    expect_at(c + 16, SigSelb, 1'b0, "live_selb_early");
    expect_at(c + 17, SigSelb, 1'b1, "live_selb");
    expect_at(c + 25, SigAck,  1'b0, "live_ack_early");
    expect_at(c + 26, SigAck,  1'b1, "live_ack");
    expect_at(c + 26, SigCur,  1'b1, "live_cur");
    req(1'b1);
    tick(30);

    // Back to clka with a second request during SETTLE: exactly one ack, nothing queued.
    c = cyc;
    expect_at(c + 1,  SigSelb, 1'b0, "back_selb");
    expect_at(c + 10, SigAck,  1'b1, "back_ack");
    expect_at(c + 10, SigCur,  1'b0, "back_cur");
    expect_at(c + 11, SigBusy, 1'b0, "back_idle");
    expect_at(c + 14, SigBusy, 1'b0, "back_no_requeue");
    req(1'b0);
    tick(2);
    req(1'b1);
    tick(30);

    // Onto clkb again, then stop the toggle.
    c = cyc;
    expect_at(c + 26, SigCur, 1'b1, "re_cur");
    req(1'b1);
    tick(30);
    tgl_per = 0;
    c = cyc;
    expect_at(c + Bound, SigSelb, !WdogEn, "wdog_selb");
    expect_at(c + Bound, SigCur,  !WdogEn, "wdog_cur");
    tick(Bound + 4);

    // Reset during SETTLE of a switch onto clkb.
    tgl_per = 3;
    req(1'b0);
    tick(16);
    c = cyc;
    expect_at(c + 17, SigSelb, 1'b1, "abort_selb_pre");
    req(1'b1);
    tick(19);
    rst_n = 1'b0;
    #1;
    probe_expect(SigSelb, 1'b0, "abort_selb");
    probe_expect(SigBusy, 1'b0, "abort_busy");
    fire_probe();
    tick(3);
    rst_n = 1'b1;
    expect_at(c + 26, SigAck, 1'b0, "abort_no_ack");
    expect_at(c + 30, SigCur, 1'b0, "abort_cur");
    tick(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
